// File: rtl/miner_controller.sv
// rtl/miner_controller.sv - SHA-256 mining lane sequencer
// Loads the job header, launches the hash core and steps the nonce until a hit or exhaustion.
module miner_controller #(
  parameter int                 NONCE_W    = 32,
  parameter logic [NONCE_W-1:0] NONCE_LAST = {NONCE_W{1'b1}}
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start_found,
  input  logic               midstate_shifts_done,
  input  logic               remaining_shifts_done,
  input  logic               hash_done,
  input  logic               hash_hit,
  output logic [2:0]         controller_state,
  output logic               shift_en,
  output logic               hash_start,
  output logic [NONCE_W-1:0] nonce,
  output logic               found,
  output logic               exhausted
);

  // Encoding is decoded by the shift timer and must not change.
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    LOAD_MID  = 3'b001,
    LOAD_REM  = 3'b010,
    LAUNCH    = 3'b011,
    HASH      = 3'b100,
    FOUND     = 3'b101,
    EXHAUSTED = 3'b110
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      nonce      <= '0;
      hash_start <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
    end else begin
      hash_start <= 1'b0;
      // A new job overrides everything, including a same-cycle hash result.
      if (start_found) begin
        state     <= LOAD_MID;
        nonce     <= '0;
        found     <= 1'b0;
        exhausted <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD_MID: if (midstate_shifts_done) state <= LOAD_REM;
          LOAD_REM: if (remaining_shifts_done) state <= LAUNCH;
          LAUNCH: begin
            hash_start <= 1'b1;
            state      <= HASH;
          end
          HASH: begin
            if (hash_done) begin
              if (hash_hit) begin
                state <= FOUND;
                found <= 1'b1;
              end else if (nonce == NONCE_LAST) begin
                state     <= EXHAUSTED;
                exhausted <= 1'b1;
              end else begin
                // Header stays in the shift register; only the nonce changes.
                nonce <= nonce + NONCE_W'(1);
                state <= LAUNCH;
              end
            end
          end
          FOUND, EXHAUSTED: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign controller_state = state;
  assign shift_en         = (state == LOAD_MID) || (state == LOAD_REM);

endmodule

// File: tb/tb_miner_controller.sv
// tb/tb_miner_controller.sv - bench for miner_controller (32-bit and 4-bit nonce lanes)
module tb_miner_controller;

  logic clk;
  logic n_rst;
  logic start_found, hash_done, hash_hit;

  logic       mid0, rem0, se0, hs0, f0, e0;
  logic [2:0] st0;
  logic [31:0] nonce0;
  logic       mid1, rem1, se1, hs1, f1, e1;
  logic [2:0] st1;
  logic [3:0] nonce1;
  logic [4:0] tcnt0, tcnt1;

  int checks;
  int failures;

  miner_controller dut (
    .clk(clk), .n_rst(n_rst), .start_found(start_found),
    .midstate_shifts_done(mid0), .remaining_shifts_done(rem0),
    .hash_done(hash_done), .hash_hit(hash_hit),
    .controller_state(st0), .shift_en(se0), .hash_start(hs0),
    .nonce(nonce0), .found(f0), .exhausted(e0)
  );

  miner_controller #(.NONCE_W(4), .NONCE_LAST(4'hF)) dut4 (
    .clk(clk), .n_rst(n_rst), .start_found(start_found),
    .midstate_shifts_done(mid1), .remaining_shifts_done(rem1),
    .hash_done(hash_done), .hash_hit(hash_hit),
    .controller_state(st1), .shift_en(se1), .hash_start(hs1),
    .nonce(nonce1), .found(f1), .exhausted(e1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift timers: count shifted words, cleared by start_found.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tcnt0 <= 5'd0;
    else if (start_found) tcnt0 <= 5'd0;
    else if (se0) tcnt0 <= tcnt0 + 5'd1;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tcnt1 <= 5'd0;
    else if (start_found) tcnt1 <= 5'd0;
    else if (se1) tcnt1 <= tcnt1 + 5'd1;
  end
  assign mid0 = (tcnt0 == 5'd7);
  assign rem0 = (tcnt0 == 5'd23);
  assign mid1 = (tcnt1 == 5'd7);
  assign rem1 = (tcnt1 == 5'd23);

  // Reference model: job phases, load length in cycles, nonce as an integer.
  localparam int P_IDLE = 0, P_LOAD = 1, P_LAUNCH = 2, P_HASH = 3, P_FOUND = 4, P_EXH = 5;
  typedef struct {
    int      phase;
    int      ld;
    longint  nonce;
    bit      found;
    bit      exh;
    bit      hs;
  } mdl_t;
  mdl_t mm[2];

  function automatic longint last_of(int i);
    return (i == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  function automatic int exp_state(mdl_t m);
    case (m.phase)
      P_LOAD:   return (m.ld < 8) ? 1 : 2;
      P_LAUNCH: return 3;
      P_HASH:   return 4;
      P_FOUND:  return 5;
      P_EXH:    return 6;
      default:  return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mm[i].phase = P_IDLE; mm[i].ld = 0; mm[i].nonce = 0;
      mm[i].found = 0; mm[i].exh = 0; mm[i].hs = 0;
    end
  endtask

  task automatic model_step(int i, bit sf, bit hd, bit hh);
    mdl_t m;
    m = mm[i];
    m.hs = (m.phase == P_LAUNCH) && !sf;
    if (sf) begin
      m.phase = P_LOAD; m.ld = 0; m.nonce = 0; m.found = 0; m.exh = 0;
    end else begin
      case (m.phase)
        P_LOAD:   if (m.ld == 23) m.phase = P_LAUNCH; else m.ld++;
        P_LAUNCH: m.phase = P_HASH;
        P_HASH: if (hd) begin
          if (hh) begin m.phase = P_FOUND; m.found = 1; end
          else if (m.nonce == last_of(i)) begin m.phase = P_EXH; m.exh = 1; end
          else begin m.nonce++; m.phase = P_LAUNCH; end
        end
        default: ;
      endcase
    end
    mm[i] = m;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_one(int i, logic [2:0] st, logic se, logic hs, logic [63:0] nn, logic f, logic e);
    chk($sformatf("m%0d.state", i), 64'(st), 64'(exp_state(mm[i])));
    chk($sformatf("m%0d.shift_en", i), 64'(se), 64'(mm[i].phase == P_LOAD));
    chk($sformatf("m%0d.hash_start", i), 64'(hs), 64'(mm[i].hs));
    chk($sformatf("m%0d.nonce", i), nn, 64'(mm[i].nonce));
    chk($sformatf("m%0d.found", i), 64'(f), 64'(mm[i].found));
    chk($sformatf("m%0d.exhausted", i), 64'(e), 64'(mm[i].exh));
  endtask

  task automatic cyc(input bit sf, input bit hd, input bit hh);
    start_found = sf; hash_done = hd; hash_hit = hh;
    @(posedge clk);
    model_step(0, sf, hd, hh);
    model_step(1, sf, hd, hh);
    @(negedge clk);
    cmp_one(0, st0, se0, hs0, 64'(nonce0), f0, e0);
    cmp_one(1, st1, se1, hs1, 64'(nonce1), f1, e1);
  endtask

  task automatic to_hash();
    cyc(1, 0, 0);
    repeat (25) cyc(0, 0, 0);
  endtask

  typedef struct {
    bit         sf, hd, hh;
    logic [2:0] st;
    bit         hs;
    logic [31:0] nonce;
    bit         found;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int n;
    int pulses;
    checks = 0; failures = 0;
    // Miss, miss, miss, hit; hash_done in LAUNCH and in FOUND must be ignored.
    tbl[0]  = '{0, 1, 0, 3'd3, 0, 32'd1, 0};
    tbl[1]  = '{0, 1, 1, 3'd4, 1, 32'd1, 0};
    tbl[2]  = '{0, 0, 0, 3'd4, 0, 32'd1, 0};
    tbl[3]  = '{0, 1, 0, 3'd3, 0, 32'd2, 0};
    tbl[4]  = '{0, 0, 0, 3'd4, 1, 32'd2, 0};
    tbl[5]  = '{0, 1, 0, 3'd3, 0, 32'd3, 0};
    tbl[6]  = '{0, 0, 0, 3'd4, 1, 32'd3, 0};
    tbl[7]  = '{0, 1, 1, 3'd5, 0, 32'd3, 1};
    tbl[8]  = '{0, 1, 0, 3'd5, 0, 32'd3, 1};
    tbl[9]  = '{0, 0, 0, 3'd5, 0, 32'd3, 1};
    tbl[10] = '{0, 0, 1, 3'd5, 0, 32'd3, 1};

    n_rst = 1'b0; start_found = 0; hash_done = 0; hash_hit = 0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp_one(0, st0, se0, hs0, 64'(nonce0), f0, e0);
    n_rst = 1'b1;
    repeat (3) cyc(0, 1, 1);

    // Start-to-launch latency with the timer in the loop.
    cyc(1, 0, 0);
    chk("start.mid0", 64'(st0), 64'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0);
      chk("start.mid", 64'(st0), 64'd1);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0);
      chk("start.rem", 64'(st0), 64'd2);
      chk("start.rem_hs", 64'(hs0), 64'd0);
    end
    cyc(0, 0, 0);
    chk("start.launch", 64'(st0), 64'd3);
    cyc(0, 0, 0);
    chk("start.hash_start", 64'(hs0), 64'd1);
    chk("start.nonce", 64'(nonce0), 64'd0);

    foreach (tbl[k]) begin
      cyc(tbl[k].sf, tbl[k].hd, tbl[k].hh);
      chk($sformatf("tbl%0d.state", k), 64'(st0), 64'(tbl[k].st));
      chk($sformatf("tbl%0d.hash_start", k), 64'(hs0), 64'(tbl[k].hs));
      chk($sformatf("tbl%0d.nonce", k), 64'(nonce0), 64'(tbl[k].nonce));
      chk($sformatf("tbl%0d.found", k), 64'(f0), 64'(tbl[k].found));
    end

    // start_found beats a same-cycle hit in HASH.
    to_hash();
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 1);
    chk("prio.state", 64'(st0), 64'd1);
    chk("prio.found", 64'(f0), 64'd0);
    chk("prio.nonce", 64'(nonce0), 64'd0);

    // Restart mid-LOAD_REM at word 20: full reload follows.
    cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    chk("reload.pre_state", 64'(st0), 64'd2);
    cyc(1, 0, 0);
    chk("reload.state", 64'(st0), 64'd1);
    chk("reload.timer", 64'(tcnt0), 64'd0);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc(0, 0, 0);
      if (hs0) begin n = i; break; end
    end
    chk("reload.latency", 64'(n), 64'd25);

    // 4-bit lane: always miss, must stop at 4'hF after 16 launches.
    pulses = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 200; i++) begin
      cyc(0, 1, 0);
      if (hs1) pulses++;
      if (e1) break;
    end
    chk("exh.pulses", 64'(pulses), 64'd16);
    chk("exh.flag", 64'(e1), 64'd1);
    chk("exh.nonce", 64'(nonce1), 64'hF);
    chk("exh.state", 64'(st1), 64'd6);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0);
      if (hs1) pulses++;
    end
    chk("exh.no_wrap_pulses", 64'(pulses), 64'd16);
    chk("exh.no_wrap_nonce", 64'(nonce1), 64'hF);

    // Asynchronous reset while hashing.
    to_hash();
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("areset.state", 64'(st0), 64'd0);
    chk("areset.hash_start", 64'(hs0), 64'd0);
    chk("areset.nonce", 64'(nonce0), 64'd0);
    chk("areset.shift_en", 64'(se0), 64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, 1);
      if (hs0) n++;
    end
    chk("areset.no_launch", 64'(n), 64'd0);
    chk("areset.idle", 64'(st0), 64'd0);

    // Random traffic against the model.
    cyc(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
